// File: rtl/run_ctrl.sv
// run_ctrl: run/halt/single-step control for the bus-based multi-cycle CPU.
// Produces a registered-state clock enable (cpu_en) for every datapath
// register, merges the microstep counter, counts enabled cycles (saturating)
// and optionally stops on a PC breakpoint.
//
// Optional feature macro: RUN_CTRL_BP_EN
//   defined     -> breakpoint comparator, bp_skip and sticky bp_hit are built
//   not defined -> no comparator, bp_addr/bp_en ignored, bp_hit tied 0
//
// Request handshake: run_req/step_req are level-sampled requests with no
// ready; they are accepted only on an edge where the state is IDLE (run_req
// wins), acceptance shows as cpu_en=1 in the following cycle, and they are
// ignored in every other state. halt_req/sc_clr are qualifiers from the
// control unit and only take effect in a cycle where cpu_en=1.
module run_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter int          STEP_W   = 4,
  parameter int          STEP_MAX = 15,
  parameter int          CYC_W    = 16,
  parameter int unsigned AUTO_RUN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic              sc_clr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  output logic              cpu_en,
  output logic [STEP_W-1:0] step,
  output logic [1:0]        state,
  output logic [CYC_W-1:0]  cycles,
  output logic              bp_hit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam state_e            RST_STATE = (AUTO_RUN != 0) ? ST_RUN : ST_IDLE;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic                active;
  logic                trip;
  logic                en;
  logic                boundary;
  logic                accept;

  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign en       = active && !trip;
  assign boundary = en && (sc_clr || (step_q == STEP_LAST));
  assign accept   = (state_q == ST_IDLE) && (run_req || step_req);

`ifdef RUN_CTRL_BP_EN
  logic bp_skip_q, bp_skip_d;
  logic bp_hit_q, bp_hit_d;

  // A trip only fires at the first microstep of an instruction, and never on
  // the very instruction we just resumed at (bp_skip).
  assign trip = active && bp_en && (step_q == '0) && (pc == bp_addr) && !bp_skip_q;

  // Resume bookkeeping: accept arms the skip and clears the sticky hit.
  always_comb begin
    bp_skip_d = bp_skip_q;
    bp_hit_d  = bp_hit_q;
    if (accept) begin
      bp_skip_d = 1'b1;
      bp_hit_d  = 1'b0;
    end else begin
      if (en)   bp_skip_d = 1'b0;
      if (trip) bp_hit_d  = 1'b1;
    end
  end

  // Breakpoint state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_skip_q <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
      bp_hit_q  <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;

  assign trip      = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_en};
`endif

  // Next-state logic; halt outranks the instruction boundary in STEP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = run_req ? ST_RUN : ST_STEP;
      end
      ST_RUN: begin
        if (en && halt_req) state_d = ST_HALT;
        else if (trip)      state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (en && halt_req) state_d = ST_HALT;
        else if (boundary)  state_d = ST_IDLE;
        else if (trip)      state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = RST_STATE;
    endcase
  end

  // Microstep and saturating enabled-cycle counters advance only when enabled.
  always_comb begin
    step_d = step_q;
    cyc_d  = cyc_q;
    if (en) begin
      step_d = boundary ? '0 : step_q + STEP_W'(1);
      if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
    end
  end

  // Control state registers; reset clears everything regardless of cpu_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      step_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cyc_q   <= cyc_d;
    end
  end

  assign cpu_en = en;
  assign step   = step_q;
  assign state  = state_q;
  assign cycles = cyc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: one AUTO_RUN=1 instance (16-bit cycle counter) and
// one AUTO_RUN=0 instance (5-bit cycle counter so saturation is reachable).
module tb_run_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_run, a_stp, a_halt, a_sc, a_bpen;
  logic [7:0] a_pc, a_bpaddr;
  logic       a_cpu_en, a_bp_hit;
  logic [3:0] a_step;
  logic [1:0] a_state;
  logic [15:0] a_cycles;

  logic       b_rst, b_run, b_stp, b_halt, b_sc, b_bpen;
  logic [7:0] b_pc, b_bpaddr;
  logic       b_cpu_en, b_bp_hit;
  logic [3:0] b_step;
  logic [1:0] b_state;
  logic [4:0] b_cycles;

  run_ctrl #(.ADDR_W(8), .STEP_W(4), .STEP_MAX(15), .CYC_W(16), .AUTO_RUN(1)) u_a (
    .clk(clk), .reset(a_rst), .run_req(a_run), .step_req(a_stp),
    .halt_req(a_halt), .sc_clr(a_sc), .pc(a_pc), .bp_addr(a_bpaddr),
    .bp_en(a_bpen), .cpu_en(a_cpu_en), .step(a_step), .state(a_state),
    .cycles(a_cycles), .bp_hit(a_bp_hit)
  );

  run_ctrl #(.ADDR_W(8), .STEP_W(4), .STEP_MAX(15), .CYC_W(5), .AUTO_RUN(0)) u_b (
    .clk(clk), .reset(b_rst), .run_req(b_run), .step_req(b_stp),
    .halt_req(b_halt), .sc_clr(b_sc), .pc(b_pc), .bp_addr(b_bpaddr),
    .bp_en(b_bpen), .cpu_en(b_cpu_en), .step(b_step), .state(b_state),
    .cycles(b_cycles), .bp_hit(b_bp_hit)
  );

  // Observation word: {bp_hit, cpu_en, state, step, cycles}.
  function automatic logic [31:0] pk(input logic hit, input logic en,
                                     input logic [1:0] st, input logic [3:0] sp,
                                     input logic [15:0] cy);
    return {8'h00, hit, en, st, sp, cy};
  endfunction

  logic [31:0] obs_a, obs_b;
  assign obs_a = pk(a_bp_hit, a_cpu_en, a_state, a_step, a_cycles);
  assign obs_b = pk(b_bp_hit, b_cpu_en, b_state, b_step, {11'd0, b_cycles});

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check({tag, "_underflow"}, 32'd0, 32'd1);
    else check(tag, got, exp_q.pop_front());
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive requests, queue the expected observation for
  // after the next rising edge, then sample it at the following negedge.
  task automatic cyc(input bit on_b, input logic run, input logic stp,
                     input logic halt, input logic sc,
                     input logic [31:0] exp, input string tag);
    if (on_b) begin
      b_run = run; b_stp = stp; b_halt = halt; b_sc = sc;
    end else begin
      a_run = run; a_stp = stp; a_halt = halt; a_sc = sc;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    sb_pop(tag, on_b ? obs_b : obs_a);
    a_run = 1'b0; a_stp = 1'b0; a_halt = 1'b0; a_sc = 1'b0;
    b_run = 1'b0; b_stp = 1'b0; b_halt = 1'b0; b_sc = 1'b0;
  endtask

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  initial begin
    int c;
    a_rst = 1'b1; a_run = 0; a_stp = 0; a_halt = 0; a_sc = 0;
    a_pc = 8'h00; a_bpaddr = 8'h00; a_bpen = 1'b0;
    b_rst = 1'b1; b_run = 0; b_stp = 0; b_halt = 0; b_sc = 0;
    b_pc = 8'h00; b_bpaddr = 8'h00; b_bpen = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_reset", obs_a, pk(0, 1, S_RUN, 4'd0, 16'd0));
    check("b_reset", obs_b, pk(0, 0, S_IDLE, 4'd0, 16'd0));
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    check("a_cycle0", obs_a, pk(0, 1, S_RUN, 4'd0, 16'd0));

    // ---- A: free run, sc_clr, wrap ----
    for (int i = 1; i <= 5; i++)
      cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'(i), 16'(i)), "a_count");
    cyc(A, 0, 0, 0, 1, pk(0, 1, S_RUN, 4'd0, 16'd6), "a_sc_clr");
    for (int i = 1; i <= 16; i++)
      cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'(i % 16), 16'(6 + i)), "a_wrap");

    // ---- A: asynchronous reset mid-instruction ----
    a_rst = 1'b1;
    #1;
    check("a_async_rst", obs_a, pk(0, 1, S_RUN, 4'd0, 16'd0));
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;

    // ---- A: HALT microstep then absorbing HALTED ----
    for (int i = 1; i <= 7; i++)
      cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'(i), 16'(i)), "a_pre_halt");
    cyc(A, 0, 0, 1, 0, pk(0, 0, S_HALT, 4'd8, 16'd8), "a_halt");
    cyc(A, 1, 0, 0, 0, pk(0, 0, S_HALT, 4'd8, 16'd8), "a_halt_run_ign");
    cyc(A, 0, 1, 0, 0, pk(0, 0, S_HALT, 4'd8, 16'd8), "a_halt_step_ign");
    a_rst = 1'b1;
    #1;
    check("a_halt_reset", obs_a, pk(0, 1, S_RUN, 4'd0, 16'd0));
    @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;

    // ---- A: breakpoint at 0x12 ----
    a_bpen = 1'b1; a_bpaddr = 8'h12; a_pc = 8'h10;
    cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'd1, 16'd1), "a_bp_pre1");
    cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'd2, 16'd2), "a_bp_pre2");
    cyc(A, 0, 0, 0, 1, pk(0, 1, S_RUN, 4'd0, 16'd3), "a_bp_fetch");
    a_pc = 8'h12;
    #1;
`ifdef RUN_CTRL_BP_EN
    check("a_bp_comb", obs_a, pk(0, 0, S_RUN, 4'd0, 16'd3));
    cyc(A, 0, 0, 0, 0, pk(1, 0, S_IDLE, 4'd0, 16'd3), "a_bp_idle");
    cyc(A, 1, 0, 0, 0, pk(0, 1, S_RUN, 4'd0, 16'd3), "a_bp_resume");
    cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'd1, 16'd4), "a_bp_advance");
`else
    check("a_bp_comb", obs_a, pk(0, 1, S_RUN, 4'd0, 16'd3));
    cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'd1, 16'd4), "a_bp_idle");
    cyc(A, 1, 0, 0, 0, pk(0, 1, S_RUN, 4'd2, 16'd5), "a_bp_resume");
    cyc(A, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'd3, 16'd6), "a_bp_advance");
`endif
    a_bpen = 1'b0;

    // ---- B: single step of a 5-microstep instruction ----
    cyc(B, 0, 0, 0, 0, pk(0, 0, S_IDLE, 4'd0, 16'd0), "b_idle");
    cyc(B, 0, 0, 1, 0, pk(0, 0, S_IDLE, 4'd0, 16'd0), "b_idle_halt_ign");
    cyc(B, 0, 1, 0, 0, pk(0, 1, S_STEP, 4'd0, 16'd0), "b_step_go");
    for (int i = 1; i <= 4; i++)
      cyc(B, 0, 1, 0, 0, pk(0, 1, S_STEP, 4'(i), 16'(i)), "b_step_run");
    cyc(B, 0, 0, 0, 1, pk(0, 0, S_IDLE, 4'd0, 16'd5), "b_step_end");
    cyc(B, 0, 0, 0, 0, pk(0, 0, S_IDLE, 4'd0, 16'd5), "b_idle_after");

    // ---- B: run+step together -> RUN, then cycle saturation ----
    cyc(B, 1, 1, 0, 0, pk(0, 1, S_RUN, 4'd0, 16'd5), "b_both_req");
    for (int k = 1; k <= 30; k++) begin
      c = (5 + k > 31) ? 31 : 5 + k;
      cyc(B, 0, 0, 0, 0, pk(0, 1, S_RUN, 4'(k % 16), 16'(c)), "b_sat");
    end
    cyc(B, 0, 0, 1, 1, pk(0, 0, S_HALT, 4'd0, 16'd31), "b_run_halt");

    // ---- B: halt outranks the boundary in STEP ----
    b_rst = 1'b1;
    #1;
    check("b_reset2", obs_b, pk(0, 0, S_IDLE, 4'd0, 16'd0));
    @(posedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    cyc(B, 0, 1, 0, 0, pk(0, 1, S_STEP, 4'd0, 16'd0), "b_step_go2");
    cyc(B, 0, 0, 1, 1, pk(0, 0, S_HALT, 4'd0, 16'd1), "b_step_halt_prio");
    cyc(B, 1, 0, 0, 0, pk(0, 0, S_HALT, 4'd0, 16'd1), "b_halt_run_ign");

    // ---- final report ----
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run-control and step-sequencing unit for the bus-based multi-cycle CPU. It replaces the AND-gated CPU clock with a registered clock enable and merges the microstep counter with run/halt/single-step control. It also adds a PC breakpoint and a cycle counter. The unit sits between the control unit (which supplies HALT and end-of-instruction) and every datapath register, RAM and the control unit itself, which all take `cpu_en` as a synchronous enable on `clk`.

## Interface
Parameters:
- `ADDR_W`, 8, PC / breakpoint address width
- `STEP_W`, 4, microstep counter width
- `STEP_MAX`, 15, last legal microstep; counter wraps to 0 after it
- `CYC_W`, 16, enabled-cycle counter width
- `AUTO_RUN`, 1, reset state: 1 = RUN, 0 = IDLE

Ports:
- `clk`  in  1  single system clock
- `reset`  in  1  asynchronous, active-high reset
- `run_req`  in  1  level/pulse; leave IDLE and run freely
- `step_req`  in  1  leave IDLE and execute exactly one instruction
- `halt_req`  in  1  HALT from control unit; valid only while `cpu_en`=1
- `sc_clr`  in  1  end-of-instruction from control unit; valid only while `cpu_en`=1
- `pc`  in  ADDR_W  current PC value
- `bp_addr`  in  ADDR_W  breakpoint address
- `bp_en`  in  1  breakpoint enable
- `cpu_en`  out  1  datapath clock enable (combinational from registered state)
- `step`  out  STEP_W  current microstep
- `state`  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
- `cycles`  out  CYC_W  count of enabled cycles, saturating
- `bp_hit`  out  1  sticky; set when a breakpoint stops execution

## Operation
- Instruction boundary: a cycle with `cpu_en`=1 and either `sc_clr`=1 or `step`==STEP_MAX.
- `step` increments on every `cpu_en` cycle and goes to 0 at an instruction boundary. It holds while `cpu_en`=0.
- Breakpoint trip: `bp_en`=1, `step`==0, `pc`==`bp_addr`, state is RUN or STEP, and `bp_skip`=0.
- `cpu_en` = (state is RUN or STEP) and not trip.
- IDLE:
  - `run_req` -> RUN; `run_req` wins over `step_req`.
  - `step_req` -> STEP.
  - Either transition sets `bp_skip` so that resuming at the breakpoint address does not re-trip.
- RUN:
  - `halt_req` while `cpu_en` -> HALTED.
  - Trip -> IDLE, `bp_hit` set.
- STEP:
  - Instruction boundary -> IDLE.
  - `halt_req` -> HALTED; halt has priority over the boundary.
  - Trip -> IDLE, `bp_hit` set.
- HALTED: absorbing state. Only `reset` leaves it.
- `bp_skip` clears on the first `cpu_en` cycle.
- `bp_hit` clears on the next `run_req` or `step_req` accepted in IDLE.
- `cycles` increments on each `cpu_en` cycle and saturates at all-ones (no wrap).
- `run_req`, `step_req` and `halt_req` are ignored in states where they are not listed.

## Timing
- Reset (async assert, released synchronously by the top level):
  - `state` = RUN if AUTO_RUN else IDLE
  - `step` = 0, `cycles` = 0, `bp_hit` = 0, `bp_skip` = 0
  - `cpu_en` = 1 if AUTO_RUN else 0
- `run_req`/`step_req` sampled at edge N in IDLE -> `cpu_en`=1 during cycle N+1.
- HALT microstep: `halt_req` sampled at edge N -> that cycle is still enabled (the HALT microstep executes) -> `cpu_en`=0 from cycle N+1.
- A trip deasserts `cpu_en` in the same cycle, combinationally. No datapath update occurs at the breakpoint PC.
- STEP mode: `cpu_en` stays high for exactly the instruction's microstep count, including the fetch steps.
- Reset asserted mid-instruction: all state clears immediately, regardless of `cpu_en`.

## Configuration
- `RUN_CTRL_BP_EN` defined: breakpoint comparator, `bp_skip` and `bp_hit` are built as described above.
- `RUN_CTRL_BP_EN` not defined:
  - No comparator; trip is constant 0.
  - `bp_addr` and `bp_en` are ignored.
  - `bp_hit` is tied 0.

## Test plan
- Reset with AUTO_RUN=1, 5 cycles with no `sc_clr` -> `cpu_en`=1 throughout, `step` counts 0..4, `cycles`=5.
- `sc_clr` at `step`=5 -> next `step`=0. Run 16 cycles with no `sc_clr` -> `step` wraps from 15 to 0.
- `halt_req` at cycle 7 -> `cycles` stops at 8, `state`=11. `run_req` is then ignored; `reset` -> `state`=01.
- AUTO_RUN=0: `step_req` pulse; instruction ends with `sc_clr` at `step`=4 -> exactly 5 enabled cycles, then `state`=00.
- `bp_en`=1, `bp_addr`=0x12, `pc` reaches 0x12 at `step`=0:
  - `cpu_en`=0 that cycle, `state`=00, `bp_hit`=1.
  - `run_req` -> execution resumes at 0x12 without re-trip, `bp_hit`=0.
- `run_req` and `step_req` asserted together in IDLE -> RUN. `cycles` at all-ones stays all-ones after further enabled cycles.
